// File: rtl/datapath_controller.sv
// Moore sequencer for the register-file/ALU datapath: it latches one 16-bit instruction in WAIT,
// then steps through decode, operand fetch, operate and write-back, one state per clock.
module datapath_controller #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s,
   input  logic [15:0]      instr,
   output logic             w,
   output logic             err,
   output logic [2:0]       readnum,
   output logic [2:0]       writenum,
   output logic             loada,
   output logic             loadb,
   output logic             write,
   output logic [1:0]       vsel,
   output logic             asel,
   output logic             bsel,
   output logic             loadc,
   output logic             loads,
   output logic [1:0]       alu_op,
   output logic [1:0]       shift,
   output logic [WIDTH-1:0] sximm8
);

   typedef enum logic [2:0] {
      S_WAIT    = 3'd0,
      S_DECODE  = 3'd1,
      S_ILLEGAL = 3'd2,
      S_WR_IMM  = 3'd3,
      S_GET_A   = 3'd4,
      S_GET_B   = 3'd5,
      S_OPERATE = 3'd6,
      S_WR_REG  = 3'd7
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] ir_reg;

   logic [2:0] opcode, rn, rd, rm;
   logic [1:0] op;
   logic       is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

   assign opcode = ir_reg[15:13];
   assign op     = ir_reg[12:11];
   assign rn     = ir_reg[10:8];
   assign rd     = ir_reg[7:5];
   assign rm     = ir_reg[2:0];

   assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
   assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
   assign is_alu     = (opcode == 3'b101);
   assign is_cmp     = is_alu && (op == 2'b01);
   assign is_mvn     = is_alu && (op == 2'b11);

   // The instruction register only captures on the issue edge, so s is ignored outside WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= S_WAIT;
         ir_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_WAIT && s)
            ir_reg <= instr;
      end
   end

   always_comb begin
      state_next = S_WAIT;
      w          = 1'b0;
      err        = 1'b0;
      readnum    = 3'd0;
      writenum   = 3'd0;
      loada      = 1'b0;
      loadb      = 1'b0;
      write      = 1'b0;
      vsel       = 2'b00;
      asel       = 1'b0;
      bsel       = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      case (state_reg)
         S_WAIT: begin
            w          = 1'b1;
            state_next = s ? S_DECODE : S_WAIT;
         end
         S_DECODE: begin
            if (is_mov_imm)      state_next = S_WR_IMM;
            else if (is_mov_reg) state_next = S_GET_B;
            else if (is_alu)     state_next = S_GET_A;
            else                 state_next = S_ILLEGAL;
         end
         S_ILLEGAL: begin
            err        = 1'b1;
            state_next = S_WAIT;
         end
         S_WR_IMM: begin
            write      = 1'b1;
            writenum   = rn;
            vsel       = 2'b10;
            state_next = S_WAIT;
         end
         S_GET_A: begin
            readnum    = rn;
            loada      = 1'b1;
            state_next = S_GET_B;
         end
         S_GET_B: begin
            readnum    = rm;
            loadb      = 1'b1;
            state_next = S_OPERATE;
         end
         S_OPERATE: begin
            // Zeroing A turns the ALU add into a pass-through of B (MOV) or a plain NOT B (MVN).
            asel = is_mov_reg || is_mvn;
            if (is_cmp) begin
               loads      = 1'b1;
               state_next = S_WAIT;
            end else begin
               loadc      = 1'b1;
               state_next = S_WR_REG;
            end
         end
         S_WR_REG: begin
            write      = 1'b1;
            writenum   = rd;
            vsel       = 2'b00;
            state_next = S_WAIT;
         end
         default: state_next = S_WAIT;
      endcase
   end

   assign alu_op = op;
   assign shift  = ir_reg[4:3];
   assign sximm8 = {{(WIDTH-8){ir_reg[7]}}, ir_reg[7:0]};

endmodule

// File: tb/tb_datapath_controller.sv
// Scoreboard bench: the stimulus side predicts each instruction's per-cycle output trace
// from the instruction's meaning; a monitor pops and compares one entry per clock.
module tb_datapath_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        s;
   logic [15:0] instr;
   logic        w, err, loada, loadb, write, asel, bsel, loadc, loads;
   logic [2:0]  readnum, writenum;
   logic [1:0]  vsel, alu_op, shift;
   logic [15:0] sximm8;

   datapath_controller #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .s(s), .instr(instr),
      .w(w), .err(err), .readnum(readnum), .writenum(writenum),
      .loada(loada), .loadb(loadb), .write(write), .vsel(vsel),
      .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
      .alu_op(alu_op), .shift(shift), .sximm8(sximm8)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        w, err;
      logic [2:0]  readnum, writenum;
      logic        loada, loadb, write;
      logic [1:0]  vsel;
      logic        asel, bsel, loadc, loads;
      logic [1:0]  alu_op, shift;
      logic [15:0] sximm8;
   } vec_t;

   vec_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [15:0] last_ir;

   // Idle outputs for a given latched instruction: no strobes, fields reflect the instruction.
   function automatic vec_t base(input logic [15:0] ir);
      vec_t v;
      int   imm;
      v        = '0;
      v.alu_op = ir[12:11];
      v.shift  = ir[4:3];
      imm      = int'(ir[7:0]);
      if (imm > 127) imm = imm - 256;
      v.sximm8 = imm[15:0];
      return v;
   endfunction

   function automatic vec_t dut_vec();
      vec_t v;
      v.w = w; v.err = err; v.readnum = readnum; v.writenum = writenum;
      v.loada = loada; v.loadb = loadb; v.write = write; v.vsel = vsel;
      v.asel = asel; v.bsel = bsel; v.loadc = loadc; v.loads = loads;
      v.alu_op = alu_op; v.shift = shift; v.sximm8 = sximm8;
      return v;
   endfunction

   task automatic check(input string name, input vec_t act, input vec_t exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected trace for the cycles following the issue edge, ending in the WAIT cycle.
   task automatic push_trace(input logic [15:0] ir, output int n);
      vec_t v;
      logic [2:0] opc;
      logic [1:0] op;
      opc = ir[15:13];
      op  = ir[12:11];
      n   = 0;
      v = base(ir); q.push_back(v); n++;
      if (opc == 3'b110 && op == 2'b10) begin
         v = base(ir); v.write = 1; v.writenum = ir[10:8]; v.vsel = 2'b10; q.push_back(v); n++;
      end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
         if (opc == 3'b101) begin
            v = base(ir); v.readnum = ir[10:8]; v.loada = 1; q.push_back(v); n++;
         end
         v = base(ir); v.readnum = ir[2:0]; v.loadb = 1; q.push_back(v); n++;
         v = base(ir);
         v.asel = (opc == 3'b110) || (op == 2'b11);
         if (opc == 3'b101 && op == 2'b01) v.loads = 1;
         else v.loadc = 1;
         q.push_back(v); n++;
         if (!(opc == 3'b101 && op == 2'b01)) begin
            v = base(ir); v.write = 1; v.writenum = ir[7:5]; q.push_back(v); n++;
         end
      end else begin
         v = base(ir); v.err = 1; q.push_back(v); n++;
      end
      v = base(ir); v.w = 1; q.push_back(v); n++;
   endtask

   // Called at the falling edge of a WAIT cycle; returns at the falling edge of the next WAIT cycle.
   task automatic run_instr(input logic [15:0] ir);
      int n;
      s = 1'b1;
      instr = ir;
      push_trace(ir, n);
      last_ir = ir;
      $display("issue instr=%h expect w after %0d cycles", ir, n);
      for (int i = 1; i < n; i++) begin
         @(negedge clk);
         s = 1'($urandom);
         instr = 16'($urandom);
      end
      @(negedge clk);
      s = 1'b0;
   endtask

   task automatic idle();
      vec_t v;
      s = 1'b0;
      v = base(last_ir); v.w = 1;
      q.push_back(v);
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_instr();
      logic [15:0] ir;
      int c, k;
      ir = 16'($urandom);
      k  = $urandom_range(0, 3);
      case (k)
         0: begin ir[15:13] = 3'b110; ir[12:11] = 2'b10; end
         1: begin ir[15:13] = 3'b110; ir[12:11] = 2'b00; end
         2: ir[15:13] = 3'b101;
         default: begin
            c = $urandom_range(0, 6);
            if (c < 5) ir[15:13] = 3'(c);
            else if (c == 5) ir[15:13] = 3'b111;
            else begin ir[15:13] = 3'b110; ir[11] = 1'b1; end
         end
      endcase
      return ir;
   endfunction

   always @(posedge clk) begin
      #1;
      if (q.size() > 0) check("trace", dut_vec(), q.pop_front());
   end

   initial begin
      vec_t rv, ev;
      logic [15:0] fixed[7];
      fixed = '{16'hD07F, 16'hD1F0, 16'hA2A1, 16'hAB03, 16'hE000, 16'hD07F, 16'hD1F0};
      reset = 1'b1; s = 1'b0; instr = 16'h0;
      last_ir = 16'h0;
      rv = base(16'h0); rv.w = 1;
      #3 check("reset_state", dut_vec(), rv);
      @(negedge clk);
      reset = 1'b0;
      idle();

      // Directed instructions; the last two MOV imm issue back to back with s held high.
      for (int i = 0; i < 7; i++) run_instr(fixed[i]);
      idle();

      // Reset while an ADD sits in GET_B.
      s = 1'b1; instr = 16'hA2A1;
      @(negedge clk); s = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ev = base(16'hA2A1); ev.readnum = 3'd1; ev.loadb = 1;
      check("get_b_before_reset", dut_vec(), ev);
      reset = 1'b1;
      #1 check("async_reset", dut_vec(), rv);
      @(posedge clk);
      #1 check("held_reset", dut_vec(), rv);
      @(negedge clk);
      reset = 1'b0;
      last_ir = 16'h0;
      idle();

      for (int i = 0; i < 250; i++) begin
         if ($urandom_range(0, 2) == 0) idle();
         run_instr(rand_instr());
      end
      idle();
      idle();
      @(negedge clk);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
      $fatal(1);
   end

endmodule
